mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported `Memory` between the `Cpu` (port 0) and a second bus master such as a loader or DMA engine (port 1). It registers one request at a time and holds the memory `address`, `read` and `write` strobes stable for a programmable number of access cycles. It returns read data with a one-cycle acknowledge and rotates priority round-robin so that neither master starves. The block sits between the masters and `Memory`, in place of direct CPU-to-memory wiring.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between two bus masters.
// Each transaction holds the memory strobes for LATENCY cycles, then acks for one cycle.
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [1:0]    grant_q, grant_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          elig0, elig1, pick1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;

        // A port whose ack is showing this cycle is not allowed to win again yet.
        elig0 = req0 & ~ack0_q;
        elig1 = req1 & ~ack1_q;
        pick1 = elig1 & (~elig0 | ~last_q);

        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(LATENCY);
                    last_d  = pick1;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? we1 : we0;
                    addr_d  = pick1 ? addr1 : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = 2'b00;
                    if (grant_q[0]) begin
                        ack0_d = 1'b1;
                        if (!we_q) rdata0_d = mem_rdata;
                    end else begin
                        ack1_d = 1'b1;
                        if (!we_q) rdata1_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            grant_q  <= 2'b00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    assign busy      = (state_q == ACCESS);
    assign read      = busy & ~we_q;
    assign write     = busy & we_q;
    assign grant     = grant_q;
    assign address   = addr_q;
    assign mem_wdata = wdata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LATENCY=1 instance driven from a vector table and a
// LATENCY=3 instance exercised by hand-written multi-cycle sequences.
module tb_mem_arbiter;

    localparam logic [31:0] A100 = 32'h0000_0100;
    localparam logic [31:0] A200 = 32'h0000_0200;
    localparam logic [31:0] A300 = 32'h0000_0300;
    localparam logic [31:0] DBEF = 32'hDEAD_BEEF;
    localparam logic [31:0] CF0D = 32'hCAFE_F00D;
    localparam logic [31:0] WVAL = 32'h1234_5678;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        a_ack0, a_ack1, a_read, a_write, a_busy;
    logic [1:0]  a_grant;
    logic [31:0] a_rdata0, a_rdata1, a_address, a_mem_wdata, a_mem_rdata;
    logic        b_ack0, b_ack1, b_read, b_write, b_busy;
    logic [1:0]  b_grant;
    logic [31:0] b_rdata0, b_rdata1, b_address, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.LATENCY(1)) dut_a (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
        .address(a_address), .read(a_read), .write(a_write),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .grant(a_grant), .busy(a_busy)
    );

    mem_arbiter #(.LATENCY(3)) dut_b (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .address(b_address), .read(b_read), .write(b_write),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .grant(b_grant), .busy(b_busy)
    );

    // Word-addressed memories, one per instance, preloaded through the load port.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    always @(posedge clock) begin
        if (load_en) begin
            mem_a[load_addr] <= load_data;
            mem_b[load_addr] <= load_data;
        end else begin
            if (a_write) mem_a[a_address[11:2]] <= a_mem_wdata;
            if (b_write) mem_b[b_address[11:2]] <= b_mem_wdata;
        end
    end

    assign a_mem_rdata = a_read ? mem_a[a_address[11:2]] : 32'h0;
    assign b_mem_rdata = b_read ? mem_b[b_address[11:2]] : 32'h0;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req0, we0;
        logic [31:0] addr0, wdata0;
        logic        req1, we1;
        logic [31:0] addr1, wdata1;
        logic        ack0, ack1;
        logic [1:0]  grant;
        logic        read, write, busy;
        logic [31:0] address, rdata0, rdata1;
    } vec_t;

    vec_t vecs [12];

    task automatic clear_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic reset_dut();
        @(negedge clock);
        resetn = 1'b0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Waits for the selected ack on the LATENCY=3 instance; -1 means it never came.
    task automatic wait_ack_b(input int which, input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock);
            if ((which == 0) ? b_ack0 : b_ack1) begin
                cycles = k;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int pulses;
        vec_t v;

        vecs[0]  = '{1'b1,1'b0,A100,32'h0, 1'b0,1'b0,A300,32'h0, 1'b0,1'b0,2'b01,1'b1,1'b0,1'b1, A100,32'h0,32'h0};
        vecs[1]  = '{1'b1,1'b0,A100,32'h0, 1'b0,1'b0,A300,32'h0, 1'b1,1'b0,2'b00,1'b0,1'b0,1'b0, A100,DBEF,32'h0};
        vecs[2]  = '{1'b1,1'b0,A100,32'h0, 1'b0,1'b0,A300,32'h0, 1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, A100,DBEF,32'h0};
        vecs[3]  = '{1'b1,1'b0,A100,32'h0, 1'b0,1'b0,A300,32'h0, 1'b0,1'b0,2'b01,1'b1,1'b0,1'b1, A100,DBEF,32'h0};
        vecs[4]  = '{1'b1,1'b0,A100,32'h0, 1'b0,1'b0,A300,32'h0, 1'b1,1'b0,2'b00,1'b0,1'b0,1'b0, A100,DBEF,32'h0};
        vecs[5]  = '{1'b1,1'b0,A100,32'h0, 1'b1,1'b0,A300,32'h0, 1'b0,1'b0,2'b10,1'b1,1'b0,1'b1, A300,DBEF,32'h0};
        vecs[6]  = '{1'b1,1'b0,A100,32'h0, 1'b1,1'b0,A300,32'h0, 1'b0,1'b1,2'b00,1'b0,1'b0,1'b0, A300,DBEF,CF0D};
        vecs[7]  = '{1'b1,1'b0,A100,32'h0, 1'b1,1'b0,A300,32'h0, 1'b0,1'b0,2'b01,1'b1,1'b0,1'b1, A100,DBEF,CF0D};
        vecs[8]  = '{1'b1,1'b0,A100,32'h0, 1'b1,1'b0,A300,32'h0, 1'b1,1'b0,2'b00,1'b0,1'b0,1'b0, A100,DBEF,CF0D};
        vecs[9]  = '{1'b1,1'b0,A100,32'h0, 1'b1,1'b0,A300,32'h0, 1'b0,1'b0,2'b10,1'b1,1'b0,1'b1, A300,DBEF,CF0D};
        vecs[10] = '{1'b1,1'b0,A100,32'h0, 1'b1,1'b0,A300,32'h0, 1'b0,1'b1,2'b00,1'b0,1'b0,1'b0, A300,DBEF,CF0D};
        vecs[11] = '{1'b0,1'b0,A100,32'h0, 1'b0,1'b0,A300,32'h0, 1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, A300,DBEF,CF0D};

        clear_inputs();
        load_en = 1'b0; load_addr = '0; load_data = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check("reset_a", {a_ack0,a_ack1,a_grant,a_read,a_write,a_busy,a_address,a_mem_wdata,a_rdata0,a_rdata1}, 104'h0);
        check("reset_b", {b_ack0,b_ack1,b_grant,b_read,b_write,b_busy,b_address,b_mem_wdata,b_rdata0,b_rdata1}, 104'h0);

        load_en = 1'b1;
        load_addr = A100[11:2]; load_data = DBEF; @(negedge clock);
        load_addr = A300[11:2]; load_data = CF0D; @(negedge clock);
        load_addr = A200[11:2]; load_data = 32'h0; @(negedge clock);
        load_en = 1'b0;
        resetn = 1'b1;

        // Table: single read, masked re-request, then continuous contention (LATENCY=1).
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
            req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
            @(negedge clock);
            check($sformatf("vec%0d", i),
                  {a_ack0,a_ack1,a_grant,a_read,a_write,a_busy,a_address,a_rdata0,a_rdata1},
                  {v.ack0,v.ack1,v.grant,v.read,v.write,v.busy,v.address,v.rdata0,v.rdata1});
        end

        // Port-1 write held for three cycles, then a port-0 read of the same word.
        reset_dut();
        req1 = 1'b1; we1 = 1'b1; addr1 = A200; wdata1 = WVAL;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("wr_cycle%0d", k),
                  {b_ack1,b_write,b_read,b_grant,b_busy,b_address,b_mem_wdata},
                  {1'b0,1'b1,1'b0,2'b10,1'b1,A200,WVAL});
        end
        @(negedge clock);
        check("wr_ack", {b_ack1,b_write,b_grant,b_busy,b_rdata1}, {1'b1,1'b0,2'b00,1'b0,32'h0});
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = A200;
        wait_ack_b(0, 20, cyc);
        check("rd_after_wr_latency", cyc, 4);
        check("rd_after_wr_data", {b_rdata0,b_rdata1}, {WVAL,32'h0});
        req0 = 1'b0;

        // Reset in the second cycle of a read aborts it with no ack.
        reset_dut();
        req0 = 1'b1; we0 = 1'b0; addr0 = A100;
        @(negedge clock);
        check("abort_started", {b_read,b_grant,b_busy}, {1'b1,2'b01,1'b1});
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("abort_dropped", {b_read,b_grant,b_busy,b_ack0}, 5'b0);
        @(negedge clock);
        @(negedge clock);
        check("abort_no_ack", {b_ack0,b_busy}, 2'b0);
        resetn = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = A300;
        @(negedge clock);
        check("tie_after_reset", b_grant, 2'b01);
        wait_ack_b(0, 10, cyc);
        check("tie_ack0_latency", cyc, 3);
        check("tie_rdata0", b_rdata0, DBEF);
        req0 = 1'b0;
        @(negedge clock);
        check("loser_granted", {b_grant,b_address}, {2'b10,A300});
        wait_ack_b(1, 10, cyc);
        check("loser_ack_latency", cyc, 3);
        check("loser_rdata1", b_rdata1, CF0D);
        req1 = 1'b0;

        // Requester withdraws after the grant edge; the transaction still acks once.
        req0 = 1'b1; we0 = 1'b0; addr0 = A300;
        @(negedge clock);
        check("drop_granted", b_grant, 2'b01);
        req0 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (b_ack0) pulses++;
        end
        check("drop_ack_pulses", pulses, 1);
        check("drop_rdata0", b_rdata0, CF0D);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
